// File: rtl/simon_sequencer.sv
// Simon colour sequencer: regenerates the colour sequence from a latched seed
// with a Galois LFSR, plays it back as timed flashes, and checks player guesses.
module simon_sequencer #(
  parameter int unsigned ON_CYCLES    = 25000000,
  parameter int unsigned OFF_CYCLES   = 12500000,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  input  logic        seed_load,
  input  logic [7:0]  len,
  input  logic        play,
  input  logic        check,
  input  logic        abort,
  input  logic        guess_valid,
  input  logic [1:0]  guess_color,
  output logic [1:0]  color,
  output logic        color_en,
  output logic        busy,
  output logic        play_done,
  output logic        guess_ok,
  output logic        guess_bad,
  output logic        round_done
);

  // state        | meaning
  // S_IDLE       | waiting for seed_load / play / check
  // S_PLAY_STEP  | advance LFSR, latch next colour to show
  // S_PLAY_ON    | colour lit for ON_CYCLES
  // S_PLAY_OFF   | dark for OFF_CYCLES, then next colour or done
  // S_CHECK_STEP | advance LFSR, latch expected colour
  // S_CHECK_WAIT | waiting for the player's press

  localparam int unsigned TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int          TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PLAY_STEP, S_PLAY_ON, S_PLAY_OFF, S_CHECK_STEP, S_CHECK_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   seed_reg_q, seed_reg_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    len_q, len_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    cur_q, cur_d;
  logic          color_en_q, busy_q;
  logic          play_done_q, play_done_d;
  logic          guess_ok_q, guess_ok_d;
  logic          guess_bad_q, guess_bad_d;
  logic          round_done_q, round_done_d;
  logic [15:0]   lfsr_step;
  logic          last_elem;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always_comb begin
    state_d      = state_q;
    seed_reg_d   = seed_reg_q;
    lfsr_d       = lfsr_q;
    idx_d        = idx_q;
    len_d        = len_q;
    timer_d      = timer_q;
    cur_d        = cur_q;
    play_done_d  = 1'b0;
    guess_ok_d   = 1'b0;
    guess_bad_d  = 1'b0;
    round_done_d = 1'b0;
    lfsr_step    = lfsr_next(lfsr_q);
    // 9-bit compare so len=255 terminates without idx wrapping
    last_elem    = ({1'b0, idx_q} + 9'd1) == {1'b0, len_q};

    if (abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (play) begin
            if (len == 8'd0) begin
              play_done_d = 1'b1;
            end else begin
              len_d   = len;
              lfsr_d  = seed_reg_q;
              idx_d   = '0;
              state_d = S_PLAY_STEP;
            end
          end else if (check) begin
            if (len == 8'd0) begin
              round_done_d = 1'b1;
            end else begin
              len_d   = len;
              lfsr_d  = seed_reg_q;
              idx_d   = '0;
              state_d = S_CHECK_STEP;
            end
          end else if (seed_load) begin
            seed_reg_d = (seed == 16'h0000) ? DEFAULT_SEED : seed;
          end
        end
        S_PLAY_STEP: begin
          lfsr_d  = lfsr_step;
          cur_d   = lfsr_step[1:0];
          timer_d = '0;
          state_d = S_PLAY_ON;
        end
        S_PLAY_ON: begin
          if (timer_q == ON_LAST) begin
            timer_d = '0;
            state_d = S_PLAY_OFF;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_PLAY_OFF: begin
          if (timer_q == OFF_LAST) begin
            timer_d = '0;
            if (last_elem) begin
              play_done_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              idx_d   = idx_q + 8'd1;
              state_d = S_PLAY_STEP;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_CHECK_STEP: begin
          lfsr_d  = lfsr_step;
          cur_d   = lfsr_step[1:0];
          state_d = S_CHECK_WAIT;
        end
        S_CHECK_WAIT: begin
          if (guess_valid) begin
            if (guess_color == cur_q) begin
              guess_ok_d = 1'b1;
              if (last_elem) begin
                round_done_d = 1'b1;
                state_d      = S_IDLE;
              end else begin
                idx_d   = idx_q + 8'd1;
                state_d = S_CHECK_STEP;
              end
            end else begin
              guess_bad_d = 1'b1;
              state_d     = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      seed_reg_q   <= DEFAULT_SEED;
      lfsr_q       <= DEFAULT_SEED;
      idx_q        <= '0;
      len_q        <= '0;
      timer_q      <= '0;
      cur_q        <= '0;
      color_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      play_done_q  <= 1'b0;
      guess_ok_q   <= 1'b0;
      guess_bad_q  <= 1'b0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      seed_reg_q   <= seed_reg_d;
      lfsr_q       <= lfsr_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      timer_q      <= timer_d;
      cur_q        <= cur_d;
      color_en_q   <= (state_d == S_PLAY_ON);
      busy_q       <= (state_d != S_IDLE);
      play_done_q  <= play_done_d;
      guess_ok_q   <= guess_ok_d;
      guess_bad_q  <= guess_bad_d;
      round_done_q <= round_done_d;
    end
  end

  assign color      = cur_q;
  assign color_en   = color_en_q;
  assign busy       = busy_q;
  assign play_done  = play_done_q;
  assign guess_ok   = guess_ok_q;
  assign guess_bad  = guess_bad_q;
  assign round_done = round_done_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer with short flash timing (ON=4, OFF=2).
module tb_simon_sequencer;
  localparam int ON  = 4;
  localparam int OFF = 2;

  logic        clk = 1'b0;
  logic        reset, seed_load, play, check, abort, guess_valid;
  logic [15:0] seed;
  logic [7:0]  len;
  logic [1:0]  guess_color, color;
  logic        color_en, busy, play_done, guess_ok, guess_bad, round_done;

  int n_checks = 0;
  int n_errors = 0;

  simon_sequencer #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .DEFAULT_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .seed(seed), .seed_load(seed_load), .len(len),
    .play(play), .check(check), .abort(abort), .guess_valid(guess_valid),
    .guess_color(guess_color), .color(color), .color_en(color_en), .busy(busy),
    .play_done(play_done), .guess_ok(guess_ok), .guess_bad(guess_bad),
    .round_done(round_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs after the command edge; first lit cycle is expected one edge later.
  task automatic observe_play(input string tag, input int n, input logic [7:0] exp_cols);
    int runs = 0, hi = 0, lo = 0, done = 0, first = -1;
    logic prev_en = 1'b0;
    for (int cyc = 1; cyc <= 200 && done == 0; cyc++) begin
      step();
      if (color_en && !prev_en) begin
        if (first < 0) first = cyc;
        if (runs > 0) chk({tag, "_gap"}, lo, OFF + 1);
        if (runs < 4) chk({tag, "_col"}, color, exp_cols[2*runs +: 2]);
        hi = 1;
      end else if (color_en) begin
        hi++;
      end else if (prev_en) begin
        chk({tag, "_on_len"}, hi, ON);
        runs++;
        lo = 1;
      end else begin
        lo++;
      end
      if (play_done) begin
        done++;
        chk({tag, "_done_lat"}, lo, OFF + 1);
        chk({tag, "_done_busy"}, busy, 0);
      end
      prev_en = color_en;
    end
    chk({tag, "_first_lit"}, first, 1);
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_runs"}, runs, n);
    step();
    chk({tag, "_done_pulse"}, play_done, 0);
  endtask

  task automatic guess(input string tag, input logic [1:0] c,
                       input logic ok, input logic bad, input logic rd);
    guess_valid = 1'b1;
    guess_color = c;
    step();
    guess_valid = 1'b0;
    chk({tag, "_ok"}, guess_ok, ok);
    chk({tag, "_bad"}, guess_bad, bad);
    chk({tag, "_round"}, round_done, rd);
  endtask

  initial begin
    int rises;
    logic prev;
    reset = 1'b1; seed_load = 0; play = 0; check = 0; abort = 0;
    guess_valid = 0; seed = '0; len = '0; guess_color = '0;
    step(); step();
    chk("rst_color", color, 0);
    chk("rst_color_en", color_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {play_done, guess_ok, guess_bad, round_done}, 0);
    reset = 1'b0;
    step();

    // default seed sequence 0,0,0,2
    play = 1; len = 4; step(); play = 0;
    chk("p1_busy", busy, 1);
    chk("p1_en_lat", color_en, 0);
    observe_play("p1", 4, {2'd2, 2'd0, 2'd0, 2'd0});

    // seed 3 -> first colour 1; zero seed -> default seed
    seed = 16'h0003; seed_load = 1; step(); seed_load = 0;
    play = 1; len = 1; step(); play = 0;
    observe_play("seed3", 1, 8'h01);
    seed = 16'h0000; seed_load = 1; step(); seed_load = 0;
    play = 1; len = 1; step(); play = 0;
    observe_play("seed0", 1, 8'h00);

    // full correct round; guess during CHECK_STEP ignored
    check = 1; len = 4; step(); check = 0;
    chk("c1_busy", busy, 1);
    guess("c1_ign", 2'd3, 0, 0, 0);
    chk("c1_ign_busy", busy, 1);
    guess("c1_g0", 2'd0, 1, 0, 0); step();
    guess("c1_g1", 2'd0, 1, 0, 0); step();
    guess("c1_g2", 2'd0, 1, 0, 0); step();
    guess("c1_g3", 2'd2, 1, 0, 1);
    chk("c1_idle", busy, 0);

    // wrong third guess
    check = 1; len = 4; step(); check = 0; step();
    guess("c2_g0", 2'd0, 1, 0, 0); step();
    guess("c2_g1", 2'd0, 1, 0, 0); step();
    guess("c2_g2", 2'd1, 0, 1, 0);
    chk("c2_idle", busy, 0);
    step();
    chk("c2_bad_pulse", guess_bad, 0);
    chk("c2_no_round", round_done, 0);

    // abort in 2nd PLAY_ON; seed_load and len change while busy are ignored
    play = 1; len = 4; step(); play = 0;
    seed = 16'h0003; seed_load = 1; len = 1;
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 100 && rises < 2; i++) begin
      step();
      seed_load = 0;
      if (color_en && !prev) rises++;
      prev = color_en;
    end
    chk("ab_reach", rises, 2);
    step();
    abort = 1; step(); abort = 0;
    chk("ab_en", color_en, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", play_done, 0);
    step(); step();
    chk("ab_done2", play_done, 0);
    play = 1; len = 4; step(); play = 0;
    observe_play("ab_re", 4, {2'd2, 2'd0, 2'd0, 2'd0});

    // play and check together -> playback only
    play = 1; check = 1; len = 2; step(); play = 0; check = 0;
    observe_play("pc", 2, 8'h00);

    // zero length commands
    play = 1; len = 0; step(); play = 0;
    chk("z_play_done", play_done, 1);
    chk("z_play_busy", busy, 0);
    step();
    chk("z_play_pulse", play_done, 0);
    chk("z_play_busy2", busy, 0);
    check = 1; len = 0; step(); check = 0;
    chk("z_round", round_done, 1);
    chk("z_round_busy", busy, 0);

    // reset mid-play restores default seed
    seed = 16'h0003; seed_load = 1; step(); seed_load = 0;
    play = 1; len = 3; step(); play = 0;
    step(); step(); step();
    reset = 1; step(); reset = 0;
    chk("mr_busy", busy, 0);
    chk("mr_en", color_en, 0);
    play = 1; len = 1; step(); play = 0;
    observe_play("mr", 1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
